// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, parity mode and receiver states.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam bit UART_PARITY_EVEN = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } rx_state_t;

    function automatic logic uart_parity(
        input logic [UART_DATA_BITS-1:0] data
    );
        return UART_PARITY_EVEN ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous serial line.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fpga.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
module uart_rx_fpga
    import uart_pkg::*;
#(
    parameter int clksPerBit = 234
) (
    input  logic                      i_clkRx,
    input  logic                      i_reset,
    input  logic                      i_txBit,
    output logic                      o_rxFinished,
    output logic [UART_DATA_BITS-1:0] o_rxBits,
    output logic                      o_parityError
);

    localparam int CW = $clog2(clksPerBit);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_CNT = CW'(clksPerBit / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(clksPerBit - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

    rx_state_t                 state;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic                      parity_bit;
    logic                      rx_sync;

    uart_rx_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(i_clkRx),
        .rst(i_reset),
        .d  (i_txBit),
        .q  (rx_sync)
    );

    always_ff @(posedge i_clkRx or posedge i_reset) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            parity_bit    <= 1'b0;
            o_rxFinished  <= 1'b0;
            o_rxBits      <= '0;
            o_parityError <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_CNT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= rx_sync;
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_PARITY;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt == LAST_CNT) begin
                        cnt        <= '0;
                        parity_bit <= rx_sync;
                        state      <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A low stop sample is deliberately not treated as an error.
                ST_STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt           <= '0;
                        o_rxBits      <= shift_reg;
                        o_parityError <= parity_bit ^ uart_parity(shift_reg);
                        o_rxFinished  <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A low line here is the next start bit: go straight to START.
                ST_DONE: begin
                    if (!rx_sync) begin
                        o_rxFinished <= 1'b0;
                        cnt          <= '0;
                        state        <= ST_START;
                    end else if (cnt == LAST_CNT) begin
                        o_rxFinished <= 1'b0;
                        cnt          <= '0;
                        state        <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fpga.sv
// Directed self-checking bench for uart_rx_fpga.
module tb_uart_rx_fpga;

    localparam int N = 16;

    logic       tb_clk;
    logic       rst;
    logic       tx_bit;
    logic       rx_finished;
    logic [7:0] rx_bits;
    logic       parity_error;

    int vectors;
    int miscompares;

    logic [7:0] got_bits[$];
    logic       got_perr[$];
    logic       fin_q;
    int         hi_cnt;
    int         last_width;

    uart_rx_fpga #(
        .clksPerBit(N)
    ) dut (
        .i_clkRx      (tb_clk),
        .i_reset      (rst),
        .i_txBit      (tx_bit),
        .o_rxFinished (rx_finished),
        .o_rxBits     (rx_bits),
        .o_parityError(parity_error)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Record every completion and the width of each o_rxFinished pulse.
    always @(negedge tb_clk) begin
        if (rx_finished) begin
            if (!fin_q) begin
                got_bits.push_back(rx_bits);
                got_perr.push_back(parity_error);
                hi_cnt = 1;
            end else begin
                hi_cnt = hi_cnt + 1;
            end
        end else if (fin_q) begin
            last_width = hi_cnt;
        end
        fin_q = rx_finished;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge tb_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic stop);
        @(negedge tb_clk);
        tx_bit = 1'b0;
        idle(N);
        for (int i = 0; i < 8; i++) begin
            tx_bit = d[i];
            idle(N);
        end
        tx_bit = p;
        idle(N);
        tx_bit = stop;
        idle(N);
        tx_bit = 1'b1;
    endtask

    task automatic check_frame(input string name, input int n0,
                               input logic [7:0] exp_bits,
                               input logic exp_perr);
        logic [7:0] ob;
        logic       op;
        ob = (got_bits.size() > n0) ? got_bits[n0] : 8'hxx;
        op = (got_perr.size() > n0) ? got_perr[n0] : 1'bx;
        vectors++;
        if (ob !== exp_bits) begin
            miscompares++;
            $display("FAIL %s bits: got %h want %h", name, ob, exp_bits);
        end
        vectors++;
        if (op !== exp_perr) begin
            miscompares++;
            $display("FAIL %s perr: got %b want %b", name, op, exp_perr);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        tx_bit = 1'b1;
        idle(3);
        vectors++;
        if (rx_finished !== 1'b0) begin
            miscompares++;
            $display("FAIL reset fin: got %b want 0", rx_finished);
        end
        vectors++;
        if (rx_bits !== 8'h00) begin
            miscompares++;
            $display("FAIL reset bits: got %h want 00", rx_bits);
        end
        vectors++;
        if (parity_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset perr: got %b want 0", parity_error);
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_good_parity();
        int n0;
        n0 = got_bits.size();
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(2 * N);
        vectors++;
        if (got_bits.size() !== n0 + 1) begin
            miscompares++;
            $display("FAIL good count: got %0d want %0d",
                     got_bits.size(), n0 + 1);
        end
        check_frame("good", n0, 8'h5A, 1'b0);
        vectors++;
        if (last_width !== N) begin
            miscompares++;
            $display("FAIL good width: got %0d want %0d", last_width, N);
        end
        vectors++;
        if (rx_finished !== 1'b0) begin
            miscompares++;
            $display("FAIL good drop: got %b want 0", rx_finished);
        end
    endtask

    task automatic test_bad_parity();
        int n0;
        int budget;
        budget = 4 * N;
        while (rx_finished && budget > 0) begin
            idle(1);
            budget--;
        end
        vectors++;
        if (budget == 0) begin
            miscompares++;
            $display("FAIL bad wait_low: got timeout want fin low");
        end
        n0 = got_bits.size();
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(2 * N);
        check_frame("bad", n0, 8'h5A, 1'b1);
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = got_bits.size();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(2 * N);
        vectors++;
        if (got_bits.size() !== n0 + 2) begin
            miscompares++;
            $display("FAIL b2b count: got %0d want %0d",
                     got_bits.size(), n0 + 2);
        end
        check_frame("b2b_first", n0, 8'h00, 1'b0);
        check_frame("b2b_second", n0 + 1, 8'hFF, 1'b0);
    endtask

    task automatic test_glitch();
        int n0;
        n0 = got_bits.size();
        @(negedge tb_clk);
        tx_bit = 1'b0;
        idle(N / 4);
        tx_bit = 1'b1;
        idle(2 * N);
        vectors++;
        if (got_bits.size() !== n0) begin
            miscompares++;
            $display("FAIL glitch count: got %0d want %0d",
                     got_bits.size(), n0);
        end
        vectors++;
        if (rx_finished !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch fin: got %b want 0", rx_finished);
        end
        vectors++;
        if (rx_bits !== 8'hFF) begin
            miscompares++;
            $display("FAIL glitch bits: got %h want ff", rx_bits);
        end
        vectors++;
        if (parity_error !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch perr: got %b want 0", parity_error);
        end
    endtask

    task automatic test_reset_mid_frame();
        int         n0;
        logic [7:0] d;
        d = 8'h33;
        @(negedge tb_clk);
        tx_bit = 1'b0;
        idle(N);
        for (int i = 0; i < 4; i++) begin
            tx_bit = d[i];
            idle(N);
        end
        tx_bit = d[4];
        idle(N / 2);
        rst = 1'b1;
        idle(2);
        vectors++;
        if (rx_finished !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid fin: got %b want 0", rx_finished);
        end
        vectors++;
        if (rx_bits !== 8'h00) begin
            miscompares++;
            $display("FAIL rstmid bits: got %h want 00", rx_bits);
        end
        vectors++;
        if (parity_error !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid perr: got %b want 0", parity_error);
        end
        tx_bit = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2 * N);
        n0 = got_bits.size();
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(2 * N);
        vectors++;
        if (got_bits.size() !== n0 + 1) begin
            miscompares++;
            $display("FAIL rstmid count: got %0d want %0d",
                     got_bits.size(), n0 + 1);
        end
        check_frame("rstmid", n0, 8'hA5, 1'b0);
    endtask

    task automatic test_framing_error();
        int n0;
        n0 = got_bits.size();
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(2 * N);
        vectors++;
        if (got_bits.size() !== n0 + 1) begin
            miscompares++;
            $display("FAIL framing count: got %0d want %0d",
                     got_bits.size(), n0 + 1);
        end
        check_frame("framing", n0, 8'h3C, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        fin_q       = 1'b0;
        hi_cnt      = 0;
        last_width  = 0;
        rst         = 1'b1;
        tx_bit      = 1'b1;
        test_reset();
        test_good_parity();
        test_bad_parity();
        test_back_to_back();
        test_glitch();
        test_reset_mid_frame();
        test_framing_error();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
